mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Parametrised memory-access stage: successor to the pass-through MEM stage.
//  Sits between the EX/MEM and MEM/WB pipeline registers.
//  Executes load/store ops over a req/ack data bus, with byte/half/word sizing, sign/zero extension and misalignment detection.
//  Raises stallreq_o to the pipeline controller while a bus access is outstanding.
//  Non-memory ops pass wd/wreg/wdata through combinationally with zero latency.
// PARAMETERS
//  DATA_W      32  register/bus data width; power of two, >= 32
//  ADDR_W      32  byte address width
//  REG_ADDR_W  5   destination register address width
// PORTS
//  clk           in   1            clock
//  rst           in   1            async reset, active-high
//  wd_i          in   REG_ADDR_W   dest register from EX
//  wreg_i        in   1            register write enable from EX
//  wdata_i       in   DATA_W       ALU result from EX
//  mem_op_i      in   4            memory op code (package constants)
//  mem_addr_i    in   ADDR_W       effective byte address
//  store_data_i  in   DATA_W       store source (reg2)
//  flush_i       in   1            pipeline flush; discard the current op
//  wd_o          out  REG_ADDR_W   dest register to WB
//  wreg_o        out  1            write enable to WB
//  wdata_o       out  DATA_W       ALU result or load result
//  stallreq_o    out  1            stall request to the pipeline controller
//  misalign_o    out  1            misaligned access flag, to exception logic
//  dbus_req_o    out  1            bus request; held until ack
//  dbus_we_o     out  1            1 = store
//  dbus_addr_o   out  ADDR_W       address with low log2(DATA_W/8) bits cleared
//  dbus_sel_o    out  DATA_W/8     byte enables
//  dbus_wdata_o  out  DATA_W       store data, replicated across lanes
//  dbus_ack_i    in   1            single-cycle completion strobe
//  dbus_rdata_i  in   DATA_W       read data, valid with ack
// BEHAVIOUR
//  - Reset (async): state=IDLE; dbus_req_o/we_o=0; dbus_addr/sel/wdata=0; load register=0.
//    Combinational outputs under rst: wd_o=0 (NOPRegAddr), wreg_o=0, wdata_o=0, stallreq_o=0, misalign_o=0.
//  - Byte order is big-endian: byte offset k occupies bits [DATA_W-1-8k -: 8]. Lane index = addr[log2(DATA_W/8)-1:0].
//  - Ops: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
//    H needs addr[0]=0; W needs addr[1:0]=0; otherwise misaligned.
//  - Misaligned op: misalign_o=1, wreg_o=0, no bus request, no stall.
//  - Non-memory op (NONE): outputs = inputs, stallreq_o=0, FSM stays in IDLE.
//  - FSM:
//    IDLE: aligned mem op and !flush_i -> REQ.
//          On entry, register addr/sel/we/wdata and set dbus_req_o=1.
//          stallreq_o=1 in this cycle.
//    REQ:  dbus_req_o and bus fields held stable; stallreq_o=1.
//          On dbus_ack_i: capture the extended load result, drop req, -> DONE.
//          flush_i in REQ sets a discard flag; the bus access still completes (no abort).
//    DONE: stallreq_o=0 so the pipeline advances.
//          Load: wdata_o=captured result, wreg_o=wreg_i. Store: wreg_o=0.
//          If the discard flag is set: wreg_o=0.
//          Next cycle -> IDLE and the discard flag clears.
//  - Load latency: with ack in the first REQ cycle, stall is 2 cycles and the result appears in the DONE cycle.
//    Each extra wait cycle adds 1 stall cycle. There is no timeout.
//  - Load extension: LB/LH sign-extend to DATA_W; LBU/LHU zero-extend.
//    LW sign-extends when DATA_W>32.
//  - Stores: SB sel one-hot at the lane; SH two lanes; SW four lanes.
//    wdata replicates the low 8/16/32 bits of store_data_i across all lanes.
//  - EX/MEM inputs are stable while stallreq_o=1; the block relies on this and does not re-sample.
//  - dbus_ack_i outside REQ is ignored.
//  - Reset mid-REQ drops req immediately; the bus slave must tolerate an abandoned request.
//  - flush_i in IDLE with a mem op: no request is issued and wreg_o=0.
// STRUCTURE
//  - Shared package/define file: MEM_OP_* codes, MEM_OP_W=4, FSM state encodings.
//  - Sub-module lsu_align (combinational): op + addr + data
//    -> sel, replicated wdata, misalign, extended load data.
//  - Top level holds the FSM, request registers, load capture and the pass-through mux.
// TESTING
//  - ALU op, wd_i=5, wdata_i=32'h1234 -> same-cycle wd_o=5, wdata_o=32'h1234, stallreq_o=0, no req.
//  - LB addr 0x1001, rdata 32'h00_80_00_00, ack in 1st REQ cycle
//    -> sel=4'b0100, 2 stall cycles, wdata_o=32'hFFFFFF80.
//  - LHU addr 0x2002, rdata 32'h0000_BEEF, ack after 3 wait cycles
//    -> sel=4'b0011, 5 stall cycles, wdata_o=32'h0000BEEF.
//  - SB addr 0x3003, store_data 32'hAB -> we=1, sel=4'b0001, wdata=32'hABABABAB, wreg_o=0 in DONE.
//  - LW addr 0x4002 -> misalign_o=1, wreg_o=0, dbus_req_o stays 0, stallreq_o=0.
//  - Load in REQ with flush_i pulse, then ack -> DONE with wreg_o=0.
//    Repeat with rst asserted in REQ -> req drops the same cycle, FSM is IDLE.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Memory-op codes, FSM state encoding and op-class helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

  localparam int MEM_OP_W = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
           (op == MEM_OP_LHU) || (op == MEM_OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering for big-endian loads/stores and alignment check.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [MEM_OP_W-1:0]           op_i,
  input  logic [$clog2(DATA_W/8)-1:0]   offset_i,
  input  logic [DATA_W-1:0]             store_data_i,
  input  logic [DATA_W-1:0]             rdata_i,
  output logic [DATA_W/8-1:0]           sel_o,
  output logic [DATA_W-1:0]             wdata_o,
  output logic                          misalign_o,
  output logic [DATA_W-1:0]             load_data_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [NB-1:0] ONES  = '1;
  localparam logic [NB-1:0] SEL_B = ~(ONES >> 1);
  localparam logic [NB-1:0] SEL_H = ~(ONES >> 2);
  localparam logic [NB-1:0] SEL_W = ~(ONES >> 4);

  // Shifting the addressed byte to the top makes every size read from the MSBs.
  logic [DATA_W-1:0] shifted;
  logic [7:0]        rd_b;
  logic [15:0]       rd_h;
  logic [31:0]       rd_w;
  logic [DATA_W-1:0] lw_ext;

  assign shifted = rdata_i << {offset_i, 3'b000};
  assign rd_b    = shifted[DATA_W-1 -: 8];
  assign rd_h    = shifted[DATA_W-1 -: 16];
  assign rd_w    = shifted[DATA_W-1 -: 32];

  generate
    if (DATA_W == 32) begin : g_lw_native
      assign lw_ext = rd_w;
    end else begin : g_lw_sext
      assign lw_ext = {{(DATA_W-32){rd_w[31]}}, rd_w};
    end
  endgenerate

  always_comb begin
    sel_o       = '0;
    wdata_o     = '0;
    misalign_o  = 1'b0;
    load_data_o = '0;
    case (op_i)
      MEM_OP_LB:  load_data_o = {{(DATA_W-8){rd_b[7]}}, rd_b};
      MEM_OP_LBU: load_data_o = {{(DATA_W-8){1'b0}}, rd_b};
      MEM_OP_LH: begin
        misalign_o  = offset_i[0];
        load_data_o = {{(DATA_W-16){rd_h[15]}}, rd_h};
      end
      MEM_OP_LHU: begin
        misalign_o  = offset_i[0];
        load_data_o = {{(DATA_W-16){1'b0}}, rd_h};
      end
      MEM_OP_LW: begin
        misalign_o  = |offset_i[1:0];
        load_data_o = lw_ext;
      end
      MEM_OP_SB: begin
        sel_o   = SEL_B >> offset_i;
        wdata_o = {NB{store_data_i[7:0]}};
      end
      MEM_OP_SH: begin
        misalign_o = offset_i[0];
        sel_o      = SEL_H >> offset_i;
        wdata_o    = {(NB/2){store_data_i[15:0]}};
      end
      MEM_OP_SW: begin
        misalign_o = |offset_i[1:0];
        sel_o      = SEL_W >> offset_i;
        wdata_o    = {(NB/4){store_data_i[31:0]}};
      end
      default: ;
    endcase
    // Loads still need byte enables on the bus; reuse the store lane pattern.
    case (op_i)
      MEM_OP_LB, MEM_OP_LBU: sel_o = SEL_B >> offset_i;
      MEM_OP_LH, MEM_OP_LHU: sel_o = SEL_H >> offset_i;
      MEM_OP_LW:             sel_o = SEL_W >> offset_i;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module      : mem_lsu
// Description : Load/store pipeline stage driving a req/ack data bus.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [MEM_OP_W-1:0]   mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  stallreq_o,
  output logic                  misalign_o,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [ADDR_W-1:0]     dbus_addr_o,
  output logic [DATA_W/8-1:0]   dbus_sel_o,
  output logic [DATA_W-1:0]     dbus_wdata_o,
  input  logic                  dbus_ack_i,
  input  logic [DATA_W-1:0]     dbus_rdata_i
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  logic [NB-1:0]     al_sel;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_load;
  logic              al_misalign;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .op_i         (mem_op_i),
    .offset_i     (mem_addr_i[LANE_W-1:0]),
    .store_data_i (store_data_i),
    .rdata_i      (dbus_rdata_i),
    .sel_o        (al_sel),
    .wdata_o      (al_wdata),
    .misalign_o   (al_misalign),
    .load_data_o  (al_load)
  );

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              discard_q, discard_d;

  logic is_mem;
  logic start;

  assign is_mem = op_is_load(mem_op_i) || op_is_store(mem_op_i);
  assign start  = (state_q == ST_IDLE) && is_mem && !al_misalign && !flush_i;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    load_d    = load_q;
    discard_d = discard_q;
    case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (start) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = op_is_store(mem_op_i);
          addr_d  = {mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          sel_d   = al_sel;
          wdata_d = al_wdata;
        end
      end
      ST_REQ: begin
        // A flush cannot abort the bus transfer, only suppress its writeback.
        if (flush_i) discard_d = 1'b1;
        if (dbus_ack_i) begin
          req_d   = 1'b0;
          load_d  = al_load;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        discard_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      load_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
      discard_q <= discard_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_sel_o   = sel_q;
  assign dbus_wdata_o = wdata_q;

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    if (rst) begin
      wd_o    = '0;
      wreg_o  = 1'b0;
      wdata_o = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem) begin
            wreg_o     = 1'b0;
            misalign_o = al_misalign;
            stallreq_o = start;
          end
        end
        ST_REQ: begin
          wreg_o     = 1'b0;
          stallreq_o = 1'b1;
        end
        ST_DONE: begin
          wreg_o  = wreg_i && !we_q && !discard_q && !flush_i;
          wdata_o = we_q ? wdata_i : load_q;
        end
        default: wreg_o = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu against a byte-level access model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  mem_op_i = MEM_OP_NONE;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic        flush_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, misalign_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observations recorded by run_access for the scenario tasks to judge.
  int          o_stall;
  bit          o_timeout, o_hold_bad, o_started;
  logic        o_req_seen, o_wreg_idle, o_misalign;
  logic [4:0]  o_wd;
  logic [31:0] o_wdata_idle;
  logic        o_we;
  logic [31:0] o_addr, o_bus_wdata;
  logic [3:0]  o_sel;
  logic        o_done_stall, o_done_req, o_done_wreg;
  logic [31:0] o_done_wdata;
  logic        o_rst_req, o_rst_stall;

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
      MEM_OP_LW, MEM_OP_SW:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit m_is_load(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic bit m_signed(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW};
  endfunction

  function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    if (sz == 0) return 1'b0;
    return (addr % sz) != 0;
  endfunction

  // Lane k is byte offset k; its enable bit sits at position 3-k.
  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
    logic [3:0] s = '0;
    int off = int'(addr % 4);
    for (int i = 0; i < op_size(op); i++) s[3 - (off + i)] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
    int sz = op_size(op);
    longint pat, r;
    pat = longint'(sd) & ((longint'(1) << (8 * sz)) - 1);
    r = 0;
    for (int m = 0; m < 4 / sz; m++) r = (r << (8 * sz)) | pat;
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int sz = op_size(op);
    int off = int'(addr % 4);
    longint v = 0;
    for (int i = 0; i < sz; i++)
      v = v * 256 + longint'((rd >> (8 * (3 - (off + i)))) & 32'hFF);
    if (m_signed(op) && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic idle_inputs();
    mem_op_i   = MEM_OP_NONE;
    flush_i    = 1'b0;
    dbus_ack_i = 1'b0;
  endtask

  task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rd, input logic [4:0] wdv, input logic wregv,
                            input logic [31:0] wdatav, input int waits, input bit flush_idle,
                            input int flush_at, input int rst_at);
    int cyc;
    bit done;
    o_stall = 0; o_timeout = 0; o_hold_bad = 0;
    o_done_stall = 1'b0; o_done_req = 1'b0; o_done_wreg = 1'b0; o_done_wdata = '0;
    o_rst_req = 1'b1; o_rst_stall = 1'b1;
    mem_op_i = op; mem_addr_i = addr; store_data_i = sd;
    wd_i = wdv; wreg_i = wregv; wdata_i = wdatav; flush_i = flush_idle;
    @(negedge clk);
    o_wd = wd_o; o_wreg_idle = wreg_o; o_wdata_idle = wdata_o;
    o_misalign = misalign_o; o_req_seen = dbus_req_o; o_started = stallreq_o;
    if (stallreq_o) o_stall++;
    @(posedge clk); #1;
    flush_i = 1'b0;
    if (!o_started) begin
      o_req_seen = o_req_seen | dbus_req_o;
      idle_inputs();
      return;
    end
    cyc = 0; done = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      if (!dbus_req_o) o_hold_bad = 1;
      if (cyc == 0) begin
        o_we = dbus_we_o; o_addr = dbus_addr_o; o_sel = dbus_sel_o; o_bus_wdata = dbus_wdata_o;
      end else if (o_we !== dbus_we_o || o_addr !== dbus_addr_o || o_sel !== dbus_sel_o ||
                   o_bus_wdata !== dbus_wdata_o) begin
        o_hold_bad = 1;
      end
      if (stallreq_o) o_stall++;
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        o_rst_req = dbus_req_o; o_rst_stall = stallreq_o;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        return;
      end
      flush_i = (cyc == flush_at);
      if (cyc == waits) begin
        dbus_ack_i = 1'b1;
        dbus_rdata_i = rd;
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0; flush_i = 1'b0; dbus_rdata_i = $urandom;
      if (cyc == waits) done = 1;
      cyc++;
    end
    if (!done) o_timeout = 1;
    @(negedge clk);
    o_done_stall = stallreq_o; o_done_req = dbus_req_o;
    o_done_wreg = wreg_o; o_done_wdata = wdata_o;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem_op_i = MEM_OP_LW; mem_addr_i = 32'h2; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
    #1;
    total++; if (dbus_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", dbus_req_o); end
    total++; if (dbus_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", dbus_we_o); end
    total++; if (dbus_addr_o !== 32'h0 || dbus_sel_o !== 4'h0 || dbus_wdata_o !== 32'h0) begin
      bad++; $display("FAIL rst_bus got=%h/%b/%h exp=0/0/0", dbus_addr_o, dbus_sel_o, dbus_wdata_o); end
    total++; if (wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata_o !== 32'h0) begin
      bad++; $display("FAIL rst_wb got=%0d/%b/%h exp=0/0/0", wd_o, wreg_o, wdata_o); end
    total++; if (stallreq_o !== 1'b0 || misalign_o !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%b/%b exp=0/0", stallreq_o, misalign_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_alu();
    run_access(MEM_OP_NONE, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 0, -1, -1);
    total++; if (o_wd !== 5'd5 || o_wdata_idle !== 32'h1234 || o_wreg_idle !== 1'b1) begin
      bad++; $display("FAIL alu_pass got=%0d/%h/%b exp=5/00001234/1", o_wd, o_wdata_idle, o_wreg_idle); end
    total++; if (o_started || o_req_seen !== 1'b0) begin
      bad++; $display("FAIL alu_nostall got=%b/%b exp=0/0", o_started, o_req_seen); end
  endtask

  task automatic test_load();
    run_access(MEM_OP_LB, 32'h1001, 32'h0, 32'h0080_0000, 5'd3, 1'b1, 32'h0, 0, 0, -1, -1);
    total++; if (o_sel !== 4'b0100) begin bad++; $display("FAIL lb_sel got=%b exp=0100", o_sel); end
    total++; if (o_stall != 2) begin bad++; $display("FAIL lb_stall got=%0d exp=2", o_stall); end
    total++; if (o_done_wdata !== 32'hFFFF_FF80 || o_done_wreg !== 1'b1) begin
      bad++; $display("FAIL lb_data got=%h/%b exp=ffffff80/1", o_done_wdata, o_done_wreg); end
    total++; if (o_addr !== 32'h1000 || o_we !== 1'b0 || o_hold_bad || o_timeout) begin
      bad++; $display("FAIL lb_bus got=%h/%b/%b/%b exp=00001000/0/0/0", o_addr, o_we, o_hold_bad, o_timeout); end
    run_access(MEM_OP_LHU, 32'h2002, 32'h0, 32'h0000_BEEF, 5'd4, 1'b1, 32'h0, 3, 0, -1, -1);
    total++; if (o_sel !== 4'b0011) begin bad++; $display("FAIL lhu_sel got=%b exp=0011", o_sel); end
    total++; if (o_stall != 5) begin bad++; $display("FAIL lhu_stall got=%0d exp=5", o_stall); end
    total++; if (o_done_wdata !== 32'h0000_BEEF || o_hold_bad) begin
      bad++; $display("FAIL lhu_data got=%h/%b exp=0000beef/0", o_done_wdata, o_hold_bad); end
  endtask

  task automatic test_store();
    run_access(MEM_OP_SB, 32'h3003, 32'h0000_00AB, 32'h0, 5'd7, 1'b1, 32'h55, 0, 0, -1, -1);
    total++; if (o_we !== 1'b1 || o_sel !== 4'b0001) begin
      bad++; $display("FAIL sb_we_sel got=%b/%b exp=1/0001", o_we, o_sel); end
    total++; if (o_bus_wdata !== 32'hABAB_ABAB) begin
      bad++; $display("FAIL sb_wdata got=%h exp=abababab", o_bus_wdata); end
    total++; if (o_done_wreg !== 1'b0 || o_done_stall !== 1'b0 || o_stall != 2) begin
      bad++; $display("FAIL sb_done got=%b/%b/%0d exp=0/0/2", o_done_wreg, o_done_stall, o_stall); end
  endtask

  task automatic test_misalign();
    run_access(MEM_OP_LW, 32'h4002, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0, 0, 0, -1, -1);
    total++; if (o_misalign !== 1'b1 || o_wreg_idle !== 1'b0) begin
      bad++; $display("FAIL lw_misalign got=%b/%b exp=1/0", o_misalign, o_wreg_idle); end
    total++; if (o_req_seen !== 1'b0 || o_started) begin
      bad++; $display("FAIL lw_misalign_bus got=%b/%b exp=0/0", o_req_seen, o_started); end
  endtask

  task automatic test_flush();
    run_access(MEM_OP_LW, 32'h5000, 32'h0, 32'h1234_5678, 5'd9, 1'b1, 32'h0, 2, 0, 0, -1);
    total++; if (o_done_wreg !== 1'b0 || o_stall != 4) begin
      bad++; $display("FAIL flush_req got=%b/%0d exp=0/4", o_done_wreg, o_stall); end
    run_access(MEM_OP_LW, 32'h5000, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0, 0, 1, -1, -1);
    total++; if (o_started || o_req_seen !== 1'b0 || o_wreg_idle !== 1'b0) begin
      bad++; $display("FAIL flush_idle got=%b/%b/%b exp=0/0/0", o_started, o_req_seen, o_wreg_idle); end
  endtask

  task automatic test_reset_mid_req();
    run_access(MEM_OP_LH, 32'h6002, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 5, 0, -1, 1);
    total++; if (o_rst_req !== 1'b0 || o_rst_stall !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=%b/%b exp=0/0", o_rst_req, o_rst_stall); end
    @(negedge clk);
    total++; if (dbus_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_idle got=%b/%b exp=0/0", dbus_req_o, stallreq_o); end
    @(posedge clk); #1;
    run_access(MEM_OP_LB, 32'h6003, 32'h0, 32'h0000_007F, 5'd2, 1'b1, 32'h0, 0, 0, -1, -1);
    total++; if (o_stall != 2 || o_done_wdata !== 32'h0000_007F) begin
      bad++; $display("FAIL rst_mid_after got=%0d/%h exp=2/0000007f", o_stall, o_done_wdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op;
      logic [31:0] addr, sd, rd, wdv;
      logic [4:0]  wd;
      logic        wr;
      int          waits, fat;
      bit          fidle;
      op = 4'($urandom_range(0, 8));
      addr = $urandom; sd = $urandom; rd = $urandom; wdv = $urandom;
      wd = 5'($urandom_range(0, 31)); wr = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      fidle = ($urandom_range(0, 9) == 0);
      fat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, waits) : -1;
      run_access(op, addr, sd, rd, wd, wr, wdv, waits, fidle, fat, -1);
      if (op_size(op) == 0) begin
        total++; if (o_wd !== wd || o_wreg_idle !== wr || o_wdata_idle !== wdv || o_started) begin
          bad++; $display("FAIL rnd_pass n=%0d got=%0d/%b/%h/%b exp=%0d/%b/%h/0",
                          n, o_wd, o_wreg_idle, o_wdata_idle, o_started, wd, wr, wdv); end
      end else if (m_misaligned(op, addr)) begin
        total++; if (o_misalign !== 1'b1 || o_wreg_idle !== 1'b0 || o_req_seen !== 1'b0 || o_started) begin
          bad++; $display("FAIL rnd_misalign n=%0d op=%0d got=%b/%b/%b/%b exp=1/0/0/0",
                          n, op, o_misalign, o_wreg_idle, o_req_seen, o_started); end
      end else if (fidle) begin
        total++; if (o_started || o_req_seen !== 1'b0 || o_wreg_idle !== 1'b0) begin
          bad++; $display("FAIL rnd_flush_idle n=%0d got=%b/%b/%b exp=0/0/0",
                          n, o_started, o_req_seen, o_wreg_idle); end
      end else begin
        total++; if (o_stall != waits + 2 || o_timeout || o_hold_bad) begin
          bad++; $display("FAIL rnd_stall n=%0d got=%0d/%b/%b exp=%0d/0/0",
                          n, o_stall, o_timeout, o_hold_bad, waits + 2); end
        total++; if (o_sel !== m_sel(op, addr) || o_addr !== {addr[31:2], 2'b00} ||
                     o_we !== !m_is_load(op)) begin
          bad++; $display("FAIL rnd_bus n=%0d op=%0d got=%b/%h/%b exp=%b/%h/%b", n, op,
                          o_sel, o_addr, o_we, m_sel(op, addr), {addr[31:2], 2'b00}, !m_is_load(op)); end
        if (!m_is_load(op)) begin
          total++; if (o_bus_wdata !== m_wdata(op, sd)) begin
            bad++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, o_bus_wdata, m_wdata(op, sd)); end
        end else begin
          total++; if (o_done_wdata !== m_load(op, addr, rd)) begin
            bad++; $display("FAIL rnd_load n=%0d op=%0d got=%h exp=%h", n, op, o_done_wdata,
                            m_load(op, addr, rd)); end
        end
        total++; if (o_done_wreg !== (m_is_load(op) && fat < 0 && wr) || o_done_stall !== 1'b0 ||
                     o_done_req !== 1'b0) begin
          bad++; $display("FAIL rnd_done n=%0d got=%b/%b/%b exp=%b/0/0", n, o_done_wreg,
                          o_done_stall, o_done_req, m_is_load(op) && fat < 0 && wr); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_flush();
    test_reset_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
